multdiv_ctrl: RTL and testbench

//  Sequences the shared multdiv unit for the processor's execute stage. Latches a MULT/DIV

---
 rtl/multdiv_ctrl_if.sv | 37 +++
 rtl/multdiv_ctrl.sv | 128 ++++++++++++
 tb/tb_multdiv_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/multdiv_ctrl_if.sv
// Signal bundle between the execute stage, the multdiv unit and the multdiv sequencer.
// The slave modport is the sequencer's view; master is the surrounding pipeline/unit.
interface multdiv_ctrl_if;
  logic        issue_valid;
  logic        issue_op;
  logic [31:0] issue_a;
  logic [31:0] issue_b;
  logic [4:0]  issue_rd;
  logic        flush;
  logic [31:0] md_operandA;
  logic [31:0] md_operandB;
  logic        md_ctrl_MULT;
  logic        md_ctrl_DIV;
  logic [31:0] md_result;
  logic        md_exception;
  logic        md_resultRDY;
  logic        stall;
  logic        busy;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_exception;

  modport slave (
    input  issue_valid, issue_op, issue_a, issue_b, issue_rd, flush,
    input  md_result, md_exception, md_resultRDY,
    output md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
    output stall, busy, wb_valid, wb_rd, wb_data, wb_exception
  );

  modport master (
    output issue_valid, issue_op, issue_a, issue_b, issue_rd, flush,
    output md_result, md_exception, md_resultRDY,
    input  md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
    input  stall, busy, wb_valid, wb_rd, wb_data, wb_exception
  );
endinterface

// File: rtl/multdiv_ctrl.sv
// Sequences one MULT/DIV through the shared multdiv unit: start pulse, stall until
// ready or timeout, then a single writeback (or exception record to rstatus).
module multdiv_ctrl #(
  parameter int TIMEOUT       = 40,
  parameter int EXC_RD        = 30,
  parameter int MULT_EXC_CODE = 4,
  parameter int DIV_EXC_CODE  = 5,
  parameter int TMO_EXC_CODE  = 7
) (
  input logic           clock,
  input logic           reset,
  multdiv_ctrl_if.slave bus
);
  // state | meaning
  // IDLE  | nothing in flight; accept issue_valid & !flush
  // START | one-cycle ctrl_MULT/ctrl_DIV pulse, RDY ignored
  // WAIT  | count cycles until resultRDY or timeout
  // DONE  | one-cycle writeback, pipeline released
  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;
  localparam int CW = $clog2(TIMEOUT);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          op_q;
  logic [31:0]   a_q, b_q;
  logic [4:0]    rd_q;
  logic          wb_valid_q, wb_exc_q;
  logic [4:0]    wb_rd_q;
  logic [31:0]   wb_data_q;
  logic          accept, tmo_hit, finish;

  assign accept  = (state_q == S_IDLE) && bus.issue_valid && !bus.flush;
  assign tmo_hit = (cnt_q == CW'(TIMEOUT - 1));
  assign finish  = (state_q == S_WAIT) && !bus.flush && (bus.md_resultRDY || tmo_hit);
  assign cnt_d   = (state_q == S_WAIT) ? cnt_q + CW'(1) : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (bus.issue_valid) state_d = S_START;
        S_START: state_d = S_WAIT;
        S_WAIT:  if (bus.md_resultRDY || tmo_hit) state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      op_q       <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      rd_q       <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      wb_exc_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (accept) begin
        op_q <= bus.issue_op;
        a_q  <= bus.issue_a;
        b_q  <= bus.issue_b;
        rd_q <= bus.issue_rd;
      end
      // writeback record lives for exactly the DONE cycle
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      wb_exc_q   <= 1'b0;
      if (finish) begin
        if (bus.md_resultRDY && !bus.md_exception) begin
          wb_valid_q <= (rd_q != 5'd0);
          wb_rd_q    <= rd_q;
          wb_data_q  <= bus.md_result;
        end else begin
          wb_valid_q <= 1'b1;
          wb_rd_q    <= 5'(EXC_RD);
          wb_exc_q   <= 1'b1;
          if (!bus.md_resultRDY) wb_data_q <= 32'(TMO_EXC_CODE);
          else if (op_q)         wb_data_q <= 32'(DIV_EXC_CODE);
          else                   wb_data_q <= 32'(MULT_EXC_CODE);
        end
      end
    end
  end

  always_comb begin
    bus.stall        = 1'b0;
    bus.md_ctrl_MULT = 1'b0;
    bus.md_ctrl_DIV  = 1'b0;
    bus.wb_valid     = 1'b0;
    bus.wb_rd        = '0;
    bus.wb_data      = '0;
    bus.wb_exception = 1'b0;
    case (state_q)
      S_IDLE:  bus.stall = bus.issue_valid && !bus.flush;
      S_START: begin
        bus.stall        = 1'b1;
        bus.md_ctrl_MULT = !op_q;
        bus.md_ctrl_DIV  = op_q;
      end
      S_WAIT:  bus.stall = 1'b1;
      default: begin
        // a flush arriving in DONE still kills the writeback
        if (wb_valid_q && !bus.flush) begin
          bus.wb_valid     = 1'b1;
          bus.wb_rd        = wb_rd_q;
          bus.wb_data      = wb_data_q;
          bus.wb_exception = wb_exc_q;
        end
      end
    endcase
  end

  assign bus.busy        = (state_q != S_IDLE);
  assign bus.md_operandA = a_q;
  assign bus.md_operandB = b_q;
endmodule

// File: tb/tb_multdiv_ctrl.sv
// Bench for multdiv_ctrl: directed scenarios plus random ops, with the multdiv unit
// played by the bench and writebacks predicted from plain arithmetic.
module tb_multdiv_ctrl;
  localparam int TIMEOUT = 40;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  multdiv_ctrl_if bus();
  multdiv_ctrl #(.TIMEOUT(TIMEOUT)) dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic void unit_ref(input logic op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] res, output logic exc);
    longint p;
    if (!op) begin
      p   = longint'($signed(a)) * longint'($signed(b));
      res = p[31:0];
      exc = (longint'(int'(p)) != p);
    end else begin
      exc = (b == 32'd0);
      if (exc) res = 32'd0;
      else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = a;
      else res = 32'($signed(a) / $signed(b));
    end
  endfunction

  function automatic void wb_ref(input bit tmo, input logic exc, input logic op,
                                 input logic [4:0] rd, input logic [31:0] res,
                                 output logic v, output logic [4:0] erd,
                                 output logic [31:0] d, output logic e);
    if (tmo) begin
      v = 1'b1; erd = 5'd30; d = 32'd7; e = 1'b1;
    end else if (exc) begin
      v = 1'b1; erd = 5'd30; d = op ? 32'd5 : 32'd4; e = 1'b1;
    end else begin
      v = (rd != 5'd0); erd = v ? rd : 5'd0; d = v ? res : 32'd0; e = 1'b0;
    end
  endfunction

  task automatic idle_cycle();
    @(negedge clock);
    bus.issue_valid = 1'b0; bus.flush = 1'b0; bus.md_resultRDY = 1'b0;
    #1;
    check_val("idle_busy", 32'(bus.busy), 32'd0);
    check_val("idle_stall", 32'(bus.stall), 32'd0);
    check_val("idle_wbv", 32'(bus.wb_valid), 32'd0);
    check_val("idle_wbdata", bus.wb_data, 32'd0);
  endtask

  // lat: WAIT cycle index where RDY rises (>= TIMEOUT: never)
  // flush_k: >=0 WAIT cycle index, -2 in DONE, -3 in START, -1 none
  task automatic do_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input int lat, input int flush_k, input bit stale);
    logic [31:0] res, d;
    logic        exc, v, e;
    logic [4:0]  erd;
    bit          flushed, tmo;
    flushed = 1'b0;
    tmo     = 1'b0;
    unit_ref(op, a, b, res, exc);

    @(negedge clock);
    bus.issue_valid = 1'b1; bus.issue_op = op; bus.issue_a = a; bus.issue_b = b;
    bus.issue_rd = rd; bus.flush = 1'b0; bus.md_resultRDY = 1'b0;
    #1;
    check_val("issue_stall", 32'(bus.stall), 32'd1);
    check_val("issue_busy", 32'(bus.busy), 32'd0);
    check_val("issue_wbv", 32'(bus.wb_valid), 32'd0);

    @(negedge clock);
    bus.flush = (flush_k == -3);
    #1;
    check_val("start_busy", 32'(bus.busy), 32'd1);
    check_val("start_stall", 32'(bus.stall), 32'd1);
    if (flush_k != -3) begin
      check_val("start_mult", 32'(bus.md_ctrl_MULT), 32'(!op));
      check_val("start_div", 32'(bus.md_ctrl_DIV), 32'(op));
    end
    check_val("start_opA", bus.md_operandA, a);
    check_val("start_opB", bus.md_operandB, b);
    bus.issue_a = $urandom;
    bus.issue_b = $urandom;

    if (flush_k == -3) begin
      flushed = 1'b1;
    end else begin
      for (int k = 0; k < TIMEOUT; k++) begin
        @(negedge clock);
        bus.flush        = (k == flush_k);
        bus.md_resultRDY = (k == lat);
        bus.md_result    = (k == lat) ? res : $urandom;
        bus.md_exception = (k == lat) ? exc : 1'($urandom);
        #1;
        check_val("wait_stall", 32'(bus.stall), 32'd1);
        check_val("wait_busy", 32'(bus.busy), 32'd1);
        check_val("wait_pulse", 32'(bus.md_ctrl_MULT | bus.md_ctrl_DIV), 32'd0);
        check_val("wait_opA", bus.md_operandA, a);
        check_val("wait_opB", bus.md_operandB, b);
        check_val("wait_wbv", 32'(bus.wb_valid), 32'd0);
        if (k == flush_k) begin flushed = 1'b1; break; end
        if (k == lat) break;
        if (k == TIMEOUT - 1) tmo = 1'b1;
      end
    end

    @(negedge clock);
    bus.md_resultRDY = 1'b0; bus.flush = 1'b0; bus.md_exception = 1'b0;
    if (flushed) begin
      bus.issue_valid  = 1'b0;
      bus.md_resultRDY = stale;
      #1;
      check_val("flush_busy", 32'(bus.busy), 32'd0);
      check_val("flush_stall", 32'(bus.stall), 32'd0);
      check_val("flush_wbv", 32'(bus.wb_valid), 32'd0);
    end else begin
      bus.issue_valid = 1'($urandom);
      bus.flush       = (flush_k == -2);
      wb_ref(tmo, exc, op, rd, res, v, erd, d, e);
      if (flush_k == -2) begin v = 1'b0; erd = 5'd0; d = 32'd0; e = 1'b0; end
      #1;
      check_val("done_stall", 32'(bus.stall), 32'd0);
      check_val("done_busy", 32'(bus.busy), 32'd1);
      check_val("done_wbv", 32'(bus.wb_valid), 32'(v));
      check_val("done_wbrd", 32'(bus.wb_rd), 32'(erd));
      check_val("done_wbdata", bus.wb_data, d);
      check_val("done_wbexc", 32'(bus.wb_exception), 32'(e));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_stall"}, 32'(bus.stall), 32'd0);
    check_val({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check_val({tag, "_pulse"}, 32'(bus.md_ctrl_MULT | bus.md_ctrl_DIV), 32'd0);
    check_val({tag, "_opA"}, bus.md_operandA, 32'd0);
    check_val({tag, "_opB"}, bus.md_operandB, 32'd0);
    check_val({tag, "_wbv"}, 32'(bus.wb_valid), 32'd0);
    check_val({tag, "_wbrd"}, 32'(bus.wb_rd), 32'd0);
    check_val({tag, "_wbdata"}, bus.wb_data, 32'd0);
    check_val({tag, "_wbexc"}, 32'(bus.wb_exception), 32'd0);
  endtask

  initial begin
    logic [31:0] a, b;
    int          r, lat, fk;

    bus.issue_valid = 1'b0; bus.issue_op = 1'b0; bus.issue_a = '0; bus.issue_b = '0;
    bus.issue_rd = '0; bus.flush = 1'b0; bus.md_result = '0; bus.md_exception = 1'b0;
    bus.md_resultRDY = 1'b0;
    #1;
    check_all_zero("por");
    @(negedge clock);
    reset = 1'b0;

    do_op(1'b0, 32'd7, 32'hFFFF_FFFD, 5'd5, 10, -1, 1'b0);
    do_op(1'b1, 32'd100, 32'd0, 5'd9, 20, -1, 1'b0);
    do_op(1'b0, 32'h7FFF_FFFF, 32'd2, 5'd12, 5, -1, 1'b0);
    do_op(1'b1, 32'd100, 32'd7, 5'd3, 12, -1, 1'b0);
    do_op(1'b0, 32'd11, 32'd13, 5'd4, TIMEOUT, 5, 1'b1);
    do_op(1'b1, 32'd50, 32'd5, 5'd6, TIMEOUT, -1, 1'b0);
    do_op(1'b0, 32'd9, 32'd9, 5'd7, TIMEOUT - 1, -1, 1'b0);
    do_op(1'b1, 32'hFFFF_FF9C, 32'd3, 5'd8, 0, -1, 1'b0);
    do_op(1'b0, 32'd6, 32'd7, 5'd10, 3, -2, 1'b0);
    do_op(1'b1, 32'd6, 32'd0, 5'd11, 0, -3, 1'b1);
    do_op(1'b0, 32'd2, 32'd3, 5'd0, 4, -1, 1'b0);

    // flush while idle must block the accept
    @(negedge clock);
    bus.issue_valid = 1'b1; bus.flush = 1'b1; bus.md_resultRDY = 1'b0;
    #1;
    check_val("idleflush_stall", 32'(bus.stall), 32'd0);
    idle_cycle();

    // asynchronous reset in the middle of WAIT
    @(negedge clock);
    bus.issue_valid = 1'b1; bus.issue_op = 1'b0; bus.issue_a = 32'd3; bus.issue_b = 32'd4;
    bus.issue_rd = 5'd7;
    @(negedge clock);
    bus.issue_valid = 1'b0;
    repeat (5) @(negedge clock);
    #3 reset = 1'b1;
    #1;
    check_all_zero("rst");
    @(negedge clock);
    reset = 1'b0;
    idle_cycle();
    do_op(1'b0, 32'd3, 32'd4, 5'd7, 2, -1, 1'b0);

    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 3);
      if (r == 0) begin
        a = 32'($urandom_range(0, 2000)) - 32'd1000;
        b = 32'($urandom_range(0, 2000)) - 32'd1000;
      end else begin
        a = $urandom;
        b = $urandom;
      end
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      lat = ($urandom_range(0, 9) == 0) ? TIMEOUT : $urandom_range(0, 25);
      r = $urandom_range(0, 9);
      if (r == 0)      fk = $urandom_range(0, 20);
      else if (r == 1) fk = -2;
      else if (r == 2) fk = -3;
      else             fk = -1;
      do_op(1'($urandom), a, b, 5'($urandom), lat, fk, 1'($urandom));
    end
    idle_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
